// File: rtl/fht_job_sched.sv
// Round-robin scheduler that shares one fixed-latency FHT engine among NREQ requesters.
// One job in flight: grant, launch, wait ENG_LAT cycles, capture, hand the result downstream.
module fht_job_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int W       = 8,
    parameter int ENG_LAT = 4,
    parameter int CNTW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                eng_start,
    output logic [W-1:0]        eng_data,
    input  logic [W-1:0]        eng_result,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [IDW-1:0]      out_id,
    input  logic                out_ready,
    output logic                busy,
    output logic [CNTW-1:0]     done_cnt
);

    localparam int CW = $clog2(ENG_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_r;
    logic [IDW-1:0]  last_grant_r;
    logic [IDW-1:0]  id_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    eng_data_r;
    logic            eng_start_r;
    logic            out_valid_r;
    logic [W-1:0]    out_data_r;
    logic [IDW-1:0]  out_id_r;
    logic            busy_r;
    logic [CNTW-1:0] done_cnt_r;
    logic            rst_hold_r;

    logic            grant_any_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [IDW-1:0]  scan_s;
    logic            grant_s;
    logic [NREQ-1:0] req_ready_s;
    logic [W-1:0]    job_s;

    // Rotating-priority search starting just after the last granted requester.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {IDW{1'b0}};
        scan_s      = last_grant_r;
        for (int k = 0; k < NREQ; k++) begin
            if (scan_s == IDW'(NREQ - 1)) begin
                scan_s = {IDW{1'b0}};
            end else begin
                scan_s = scan_s + IDW'(1);
            end
            if (!grant_any_s && req_valid[scan_s]) begin
                grant_any_s = 1'b1;
                grant_idx_s = scan_s;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Grants are suppressed while reset is high and for the cycle right after it.
    assign grant_s = (state_r == S_IDLE) && grant_any_s && !reset && !rst_hold_r;

    // One-hot accept for the winning requester.
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        if (grant_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
    end

    // Select the winning requester's job word.
    always_comb begin
        job_s = {W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == IDW'(i)) begin
                job_s = req_data[i*W +: W];
            end else begin
                job_s = job_s;
            end
        end
    end

    // Scheduler FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            last_grant_r <= IDW'(NREQ - 1);
            id_r         <= {IDW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            eng_data_r   <= {W{1'b0}};
            eng_start_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= {W{1'b0}};
            out_id_r     <= {IDW{1'b0}};
            busy_r       <= 1'b0;
            done_cnt_r   <= {CNTW{1'b0}};
            rst_hold_r   <= 1'b1;
        end else begin
            rst_hold_r  <= 1'b0;
            eng_start_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (grant_s) begin
                        eng_data_r   <= job_s;
                        id_r         <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        eng_start_r  <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= S_START;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_START: begin
                    cnt_r   <= CW'(1);
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    // eng_result is only looked at on this capture cycle.
                    if (cnt_r == CW'(ENG_LAT)) begin
                        out_data_r  <= eng_result;
                        out_id_r    <= id_r;
                        out_valid_r <= 1'b1;
                        done_cnt_r  <= done_cnt_r + CNTW'(1);
                        state_r     <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign eng_start = eng_start_r;
    assign eng_data  = eng_data_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_id    = out_id_r;
    assign busy      = busy_r;
    assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_fht_job_sched.sv
// Directed bench for fht_job_sched: arbitration order, latency, backpressure,
// mid-flight reset, and done-counter wrap on a narrow-counter instance.
module tb_fht_job_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        eng_start;
    logic [7:0]  eng_data;
    logic [7:0]  eng_result;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic        busy;
    logic [15:0] done_cnt;

    logic        reset2;
    logic [3:0]  req_valid2;
    logic [31:0] req_data2;
    logic [3:0]  req_ready2;
    logic        eng_start2;
    logic [7:0]  eng_data2;
    logic [7:0]  eng_result2;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic [1:0]  out_id2;
    logic        out_ready2;
    logic        busy2;
    logic [2:0]  done_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    fht_job_sched #(.NREQ(4), .IDW(2), .W(8), .ENG_LAT(4), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .eng_start(eng_start), .eng_data(eng_data),
        .eng_result(eng_result), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .out_ready(out_ready), .busy(busy), .done_cnt(done_cnt)
    );

    fht_job_sched #(.NREQ(4), .IDW(2), .W(8), .ENG_LAT(4), .CNTW(3)) dut_w3 (
        .clk(clk), .reset(reset2), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .eng_start(eng_start2), .eng_data(eng_data2),
        .eng_result(eng_result2), .out_valid(out_valid2), .out_data(out_data2),
        .out_id(out_id2), .out_ready(out_ready2), .busy(busy2), .done_cnt(done_cnt2)
    );

    // Engine model: result = job + 0x11, valid only ENG_LAT cycles after the launch cycle.
    int         age = 0;
    logic [7:0] job_seen = 8'h00;
    always @(posedge clk) begin
        if (reset) begin
            age <= 0;
        end else if (eng_start) begin
            age      <= 1;
            job_seen <= eng_data;
        end else if (age != 0) begin
            age <= age + 1;
        end
    end
    assign eng_result = (age == 4) ? 8'(job_seen + 8'h11) : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the grant cycle; returns in the cycle after the result handshake.
    task automatic run_job(input logic [3:0] exp_ready, input logic [1:0] exp_id,
                           input logic [7:0] exp_data, input logic [15:0] exp_cnt);
        chk("grant", req_ready, exp_ready);
        step();
        chk("eng_start", eng_start, 1);
        repeat (5) step();
        chk("out_valid", out_valid, 1);
        chk("out_id", out_id, exp_id);
        chk("out_data", out_data, exp_data);
        chk("done_cnt", done_cnt, exp_cnt);
        chk("hs_no_grant", req_ready, 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 4'b0000;
        req_data   = {8'h44, 8'h33, 8'h22, 8'h5A};
        out_ready  = 1'b1;
        reset2     = 1'b1;
        req_valid2 = 4'b0000;
        req_data2  = 32'h0000_0000;
        eng_result2 = 8'h00;
        out_ready2 = 1'b1;
        step();
        step();

        chk("rst_req_ready", req_ready, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_data", eng_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_cnt", done_cnt, 0);

        // Test 1: single job from requester 0.
        reset     = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("rst_hold_no_grant", req_ready, 0);
        step();
        chk("t1_grant", req_ready, 4'b0001);
        step();
        chk("t1_eng_start", eng_start, 1);
        chk("t1_eng_data", eng_data, 8'h5A);
        chk("t1_ready_off", req_ready, 0);
        chk("t1_busy", busy, 1);
        req_valid = 4'b0000;
        step();
        chk("t1_start_pulse", eng_start, 0);
        repeat (3) step();
        chk("t1_not_early", out_valid, 0);
        step();
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_id", out_id, 0);
        chk("t1_out_data", out_data, 8'h6B);
        chk("t1_done_cnt", done_cnt, 1);
        step();
        chk("t1_released", out_valid, 0);
        chk("t1_idle_busy", busy, 0);

        // Test 2: all requesting -> 0,1,2,3,0,1 every 7 cycles.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        #1;
        chk("t2_hold", req_ready, 0);
        step();
        for (int k = 0; k < 6; k++) begin
            run_job(4'(4'b0001 << (k % 4)), 2'(k % 4), 8'(8'h11 * ((k % 4) + 2)), 16'(k + 1));
        end

        // Test 3: requesters 1 and 3 after last_grant=1.
        req_valid = 4'b1010;
        #1;
        run_job(4'b1000, 2'd3, 8'h55, 16'd7);
        run_job(4'b0010, 2'd1, 8'h33, 16'd8);
        run_job(4'b1000, 2'd3, 8'h55, 16'd9);

        // Test 4: backpressure in DONE.
        req_valid = 4'b0001;
        out_ready = 1'b0;
        #1;
        chk("t4_grant", req_ready, 4'b0001);
        step();
        req_valid = 4'b1111;
        repeat (5) step();
        chk("t4_out_valid", out_valid, 1);
        chk("t4_out_data", out_data, 8'h22);
        chk("t4_done_cnt", done_cnt, 10);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_data", out_data, 8'h22);
            chk("t4_hold_id", out_id, 0);
            chk("t4_hold_ready", req_ready, 0);
            chk("t4_hold_busy", busy, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_hs_valid", out_valid, 1);
        chk("t4_hs_no_grant", req_ready, 0);
        step();
        chk("t4_after_valid", out_valid, 0);
        chk("t4_after_busy", busy, 0);

        // Test 5: reset while waiting with cnt=2.
        req_valid = 4'b0100;
        #1;
        chk("t5_grant", req_ready, 4'b0100);
        step();
        step();
        step();
        reset     = 1'b1;
        req_valid = 4'b1010;
        step();
        reset = 1'b0;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done_cnt", done_cnt, 0);
        chk("t5_eng_start", eng_start, 0);
        chk("t5_no_grant", req_ready, 0);
        step();
        chk("t5_no_result", out_valid, 0);
        run_job(4'b0010, 2'd1, 8'h33, 16'd1);

        // Test 6: 3-bit done counter wraps after 7.
        req_valid = 4'b0000;
        reset2     = 1'b0;
        req_valid2 = 4'b0001;
        for (int j = 1; j <= 8; j++) begin
            int w;
            w = 0;
            while (!out_valid2 && w < 20) begin
                step();
                w++;
            end
            chk("t6_out_valid", out_valid2, 1);
            chk("t6_done_cnt", done_cnt2, 32'(j % 8));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
